// File: rtl/fir_mac_seq.sv
// Sequential TAPS-tap signed FIR: one multiply-accumulate unit time-shared across the taps,
// runtime-loadable coefficient bank, valid/ready handshakes and a single-product bypass mode.
module fir_mac_seq #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int AW     = $clog2(TAPS),
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ce_i,
    input  logic                    mode_i,
    input  logic                    coef_we_i,
    input  logic [AW-1:0]           coef_addr_i,
    input  logic [COEF_W-1:0]       coef_data_i,
    output logic                    coef_err_o,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_W-1:0]       x_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [ACC_W-1:0]        y_o,
    output logic                    busy_o
);

    localparam int PW = DATA_W + COEF_W;

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                   state_q;
    logic signed [DATA_W-1:0] dly_q  [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  y_q;
    logic [AW:0]              k_q;
    logic                     bypass_q;
    logic                     s_ready_q;
    logic                     m_valid_q;
    logic                     busy_q;
    logic                     coef_err_q;

    logic [AW:0]              n_taps;
    logic [AW-1:0]            tap_idx;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic                     addr_ok;
    logic                     coef_wr;
    logic                     accept;

    always_comb begin
        n_taps   = bypass_q ? (AW+1)'(1) : (AW+1)'(TAPS);
        // k_q == n_taps marks the result-load cycle; keep the index in range there
        tap_idx  = (k_q < n_taps) ? k_q[AW-1:0] : '0;
        prod     = PW'(dly_q[tap_idx]) * PW'(coef_q[tap_idx]);
        prod_ext = ACC_W'(prod);
        addr_ok  = {1'b0, coef_addr_i} < (AW+1)'(TAPS);
        coef_wr  = coef_we_i && (state_q == StIdle) && addr_ok;
        accept   = (state_q == StIdle) && s_ready_q && s_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            y_q        <= '0;
            k_q        <= '0;
            bypass_q   <= 1'b0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dly_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else if (ce_i) begin
            coef_err_q <= coef_we_i && !coef_wr;
            if (coef_wr) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
            unique case (state_q)
                StIdle: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        dly_q[0] <= x_i;
                        for (int i = 1; i < TAPS; i++) begin
                            dly_q[i] <= dly_q[i-1];
                        end
                        acc_q     <= '0;
                        k_q       <= '0;
                        bypass_q  <= mode_i;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StMac;
                    end
                end
                StMac: begin
                    if (k_q == n_taps) begin
                        y_q       <= acc_q;
                        m_valid_q <= 1'b1;
                        state_q   <= StOut;
                    end else begin
                        acc_q <= acc_q + prod_ext;
                        k_q   <= k_q + 1'b1;
                    end
                end
                StOut: begin
                    if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign coef_err_o = coef_err_q;
    assign s_ready_o  = s_ready_q;
    assign m_valid_o  = m_valid_q;
    assign y_o        = y_q;
    assign busy_o     = busy_q;

endmodule
